// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters and the data memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface data_memory_arbiter_if #(
    parameter int AW = 32
) ();
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [31:0]   wdata0;
    logic [31:0]   wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [31:0]   rdata;
    logic          err;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output gnt0, gnt1, done0, done1, rdata, err,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  gnt0, gnt1, done0, done1, rdata, err,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port sequencer for the single data memory: IDLE -> ACCESS -> DONE, one transaction per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_memory_arbiter #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_t        state_q;
    logic          port_q;
    logic          oor_q;
    logic [AW-1:0] mem_address_q;
    logic [31:0]   mem_write_data_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          done0_q;
    logic          done1_q;

    logic          any_req;
    logic          grant;
    logic          win_d;
    logic          sel_we;
    logic          sel_oor;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

`ifdef DMEM_ARB_RR_EN
    logic          last_q;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
        if (bus.req0 && bus.req1) begin
            win_d = ~last_q;
        end else begin
            win_d = ~bus.req0;
        end
`else
        win_d = ~bus.req0;
`endif
    end

    // Grant is combinational so a request is accepted in the same cycle it is seen in IDLE.
    assign any_req   = bus.req0 | bus.req1;
    assign grant     = rst_n && (state_q == IDLE) && any_req;
    assign sel_we    = win_d ? bus.we1    : bus.we0;
    assign sel_addr  = win_d ? bus.addr1  : bus.addr0;
    assign sel_wdata = win_d ? bus.wdata1 : bus.wdata0;
    assign sel_oor   = (sel_addr >= DEPTH_W);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q          <= IDLE;
            port_q           <= 1'b0;
            oor_q            <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            rdata_q          <= '0;
            err_q            <= 1'b0;
            done0_q          <= 1'b0;
            done1_q          <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q           <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q           <= win_d;
                        oor_q            <= sel_oor;
                        mem_address_q    <= sel_addr;
                        mem_write_data_q <= sel_wdata;
                        mem_read_q       <= ~sel_we & ~sel_oor;
                        mem_write_q      <= sel_we & ~sel_oor;
`ifdef DMEM_ARB_RR_EN
                        last_q           <= win_d;
`endif
                        state_q          <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q          <= mem_read_q ? bus.mem_read_data : '0;
                    err_q            <= oor_q;
                    done0_q          <= ~port_q;
                    done1_q          <= port_q;
                    mem_address_q    <= '0;
                    mem_write_data_q <= '0;
                    mem_read_q       <= 1'b0;
                    mem_write_q      <= 1'b0;
                    state_q          <= DONE;
                end
                DONE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt0           = grant & ~win_d;
    assign bus.gnt1           = grant & win_d;
    assign bus.done0          = done0_q;
    assign bus.done1          = done1_q;
    assign bus.rdata          = rdata_q;
    assign bus.err            = err_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed cases then random transactions
// compared against a transaction-level model (word array plus last-grant pointer).
module tb_data_memory_arbiter;
    localparam int DEPTH = 32;
    localparam int AW    = 32;
    localparam int IW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] tb_mem    [DEPTH];
    logic [31:0] model_mem [DEPTH];
    int          last_grant;

    data_memory_arbiter_if #(.AW(AW)) bus ();

    data_memory_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 7) ? 32'd7 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Data memory: synchronous write, combinational read aliased over the low index bits.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
        end else if (bus.mem_write && (bus.mem_address < AW'(DEPTH))) begin
            tb_mem[bus.mem_address[IW-1:0]] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = tb_mem[bus.mem_address[IW-1:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem_idle(input string tag);
        check({tag, "_mem_read"},  32'(bus.mem_read),  32'd0);
        check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        check({tag, "_mem_addr"},  bus.mem_address,    32'd0);
        check({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
    endtask

    // One complete transaction: grant in cycle N, strobe in N+1, done in N+2.
    task automatic run_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1, input bit perturb);
        int            win;
        logic          we;
        logic [AW-1:0] a;
        logic [31:0]   d;
        bit            inr;
        logic [31:0]   exp_rd;

        @(posedge clk); #1;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            win = 1 - last_grant;
`else
            win = 0;
`endif
        end else begin
            win = r0 ? 0 : 1;
        end
        we  = (win == 0) ? w0 : w1;
        a   = (win == 0) ? a0 : a1;
        d   = (win == 0) ? d0 : d1;
        inr = (a < AW'(DEPTH));

        @(negedge clk);
        check("c0_gnt0",  32'(bus.gnt0),  32'(win == 0));
        check("c0_gnt1",  32'(bus.gnt1),  32'(win == 1));
        check("c0_done",  32'(bus.done0 | bus.done1), 32'd0);
        check_mem_idle("c0");
        last_grant = win;

        @(posedge clk); #1;
        if (win == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        if (perturb) begin
            if (win == 0) begin
                bus.addr0 = $urandom; bus.wdata0 = $urandom; bus.we0 = ~w0;
            end else begin
                bus.addr1 = $urandom; bus.wdata1 = $urandom; bus.we1 = ~w1;
            end
        end
        @(negedge clk);
        check("c1_mem_read",  32'(bus.mem_read),  32'(!we && inr));
        check("c1_mem_write", 32'(bus.mem_write), 32'(we && inr));
        check("c1_mem_addr",  bus.mem_address,    a);
        check("c1_mem_wdata", bus.mem_write_data, d);
        check("c1_gnt",       32'(bus.gnt0 | bus.gnt1),   32'd0);
        check("c1_done",      32'(bus.done0 | bus.done1), 32'd0);

        @(posedge clk); #1;
        @(negedge clk);
        exp_rd = (!we && inr) ? model_mem[a[IW-1:0]] : 32'd0;
        check("c2_done0", 32'(bus.done0), 32'(win == 0));
        check("c2_done1", 32'(bus.done1), 32'(win == 1));
        check("c2_rdata", bus.rdata,      exp_rd);
        check("c2_err",   32'(bus.err),   32'(!inr));
        check("c2_gnt",   32'(bus.gnt0 | bus.gnt1), 32'd0);
        check_mem_idle("c2");
        if (we && inr) model_mem[a[IW-1:0]] = d;
    endtask

    initial begin
        logic [AW-1:0] ra0, ra1;
        int            sel;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
        last_grant = 1;
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset with memory preload; outputs must be quiet even with a request pending.
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_gnt0",  32'(bus.gnt0),  32'd0);
        check("rst_done0", 32'(bus.done0), 32'd0);
        check("rst_rdata", bus.rdata,      32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        check_mem_idle("rst");
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        rst_n = 1'b1;

        // Port 1 read of word 7 straight after reset.
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'd7, '0, '0, 1'b0);
        // Port 0 write then read back.
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'd5, '0, 32'hDEAD_BEEF, '0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, '0, '0, '0, 1'b0);
        // Four tied requests with inputs disturbed after each grant.
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'(10 + i), 32'(20 + i),
                    32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 1'b1);
        // Address boundaries.
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'd32, '0, '0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, '0, 32'd32, '0, 32'h5555_AAAA, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'd31, '0, 32'hCAFE_F00D, '0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd31, '0, '0, '0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, '0, '0, '0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0027, '0, '0, '0, 1'b0);

        // Reset during the ACCESS cycle of a port 0 read.
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'd3;
        @(negedge clk);
        check("mr_gnt0", 32'(bus.gnt0), 32'd1);
        @(posedge clk); #1;
        bus.req0 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mr_strobe", 32'(bus.mem_read), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_done0", 32'(bus.done0), 32'd0);
        check("mr_rdata", bus.rdata,      32'd0);
        check("mr_err",   32'(bus.err),   32'd0);
        check_mem_idle("mr");
        last_grant = 1;
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4, '0, '0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 7))
                    0:       ra1 = AW'(DEPTH - 1);
                    1:       ra1 = AW'(DEPTH);
                    2:       ra1 = $urandom;
                    default: ra1 = AW'($urandom_range(0, DEPTH - 1));
                endcase
                if (p == 0) ra0 = ra1;
            end
            run_txn(sel[0], sel[1], 1'($urandom), 1'($urandom), ra0, ra1,
                    $urandom, $urandom, 1'($urandom));
        end

        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Sequencer that shares the single data memory between two requesters: port 0 (processor load/store path) and port 1 (debug/DMA loader). It accepts one request at a time through a req/gnt handshake, drives the memory's address, write-data, read-enable and write-enable for exactly one cycle, captures read data, and returns a one-cycle done pulse. It sits between the requesters and the data memory and is the only block that drives the memory's control inputs.

## Interface
- DEPTH, 32: number of 32-bit words in the data memory; valid word addresses 0..DEPTH-1
- AW, 32: address width of requester and memory address buses
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- req0 / req1  input  1  request from port 0 / port 1
- we0 / we1  input  1  1 = write, 0 = read; sampled with the grant
- addr0 / addr1  input  AW  word address; sampled with the grant
- wdata0 / wdata1  input  32  write data; sampled with the grant
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted, inputs captured
- done0 / done1  output  1  one-cycle pulse: transaction complete
- rdata  output  32  read data, valid while either done is high
- err  output  1  valid while done is high: address was out of range
- mem_address  output  AW  to memory address
- mem_write_data  output  32  to memory write data
- mem_read  output  1  to memory read enable
- mem_write  output  1  to memory write enable
- mem_read_data  input  32  from memory read data

## Operation
- States: IDLE, ACCESS, DONE. Reset (rst_n low at a rising edge) forces IDLE, all outputs 0, last-grant pointer = 1.
- IDLE: if any req high, pick a winner, pulse its gnt, capture its we/addr/wdata and port id into registers, go to ACCESS. Otherwise stay in IDLE.
- Winner selection (RR build): the port not in the last-grant pointer wins when both requests are high; a lone request always wins. The pointer updates to the winner on each grant.
- ACCESS: drive mem_address = captured addr and mem_write_data = captured wdata. Drive mem_read = !we or mem_write = we only if addr < DEPTH. For reads, register mem_read_data at the end of the cycle. Go to DONE.
- Out-of-range (addr >= DEPTH): no memory strobe, rdata = 0, err = 1.
- DONE: pulse done of the captured port. rdata holds the captured read data (0 for writes). Return to IDLE.
- Outside ACCESS, mem_read, mem_write, mem_address and mem_write_data are all 0.
- Requesters hold req and inputs stable until gnt. Input changes after gnt are ignored. A req held high after gnt is treated as a new request in the next IDLE.

## Timing
- req high in cycle N with the arbiter in IDLE: gnt in cycle N, memory strobe in cycle N+1, done/rdata/err in cycle N+2.
- Earliest next grant is in cycle N+3. Peak throughput is one transaction every 3 cycles.
- Only one gnt and one done are high in any cycle. gnt and done are never high together.
- rst_n low mid-transaction: IDLE on the next edge, pending done is dropped, memory strobes go low, and the pointer is reset to 1.
- Address comparison is unsigned over the full AW bits. There is no wrap-around.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration using the last-grant pointer, as described above.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie. The pointer register is not built. Port 1 can starve under continuous port 0 requests.

## Test plan
- Port 0 write addr=5, wdata=0xDEADBEEF, then read addr=5 -> one mem_write pulse with address 5; read done0 after 2 cycles with rdata=0xDEADBEEF, err=0.
- req0 and req1 both held high for 4 transactions (RR build) -> grant order 0,1,0,1. Fixed build -> 0,0,0,0.
- Port 1 read addr=32 (DEPTH=32) -> no mem_read/mem_write pulse; done1 with err=1, rdata=0.
- Port 1 read addr=7 after reset, memory word 7 = 7 -> gnt1 in cycle 0, mem_read in cycle 1, done1 in cycle 2 with rdata=7; all mem_* signals 0 in cycles 0 and 2.
- rst_n low during ACCESS of a port 0 read -> no done0 pulse; all outputs 0 next cycle; the next tied request is granted to port 0.
- addr0 and wdata0 changed in the cycle after gnt0 -> memory sees the values captured at the grant.
